tx_controller: RTL
==================

TX_CONTROLLER -- requirements
Module: tx_controller

Interface
REQ-001 The parameter CLKS_PER_BIT SHALL have default 16 and SHALL give the number of clk cycles per serial bit (legal range 2..65535).
REQ-002 The parameter DATA_BITS SHALL have default 8 and SHALL give the number of data bits per frame (legal range 5..8).
REQ-003 The parameter PARITY_EN SHALL have default 1; when it is 1 the frame SHALL include one parity bit.
REQ-004 The parameter STOP_BITS SHALL have default 1 and SHALL give the number of stop bits per frame (legal values 1 and 2).
REQ-005 clk, input, 1 bit: the single system clock; all state SHALL update on its rising edge.
REQ-006 rst, input, 1 bit: synchronous, active-high reset.
REQ-007 tx_valid, input, 1 bit: the requester has a byte ready for the PISO register.
REQ-008 tx_ready, output, 1 bit: the controller is idle and can accept a frame.
REQ-009 piso_load, output, 1 bit: one-cycle pulse that loads the PISO register.
REQ-010 piso_shift, output, 1 bit: one-cycle pulse that advances the PISO register to its next bit.
REQ-011 select, output, 2 bits: transmit-mux select; 00 = start, 01 = PISO data, 10 = parity, 11 = stop/idle.
REQ-012 busy, output, 1 bit: a frame is in progress.
REQ-013 tx_done, output, 1 bit: one-cycle pulse on completion of a frame.

Function
REQ-014 The controller SHALL implement a registered FSM with states IDLE, START, DATA, PARITY and STOP.
REQ-015 In IDLE: select = 11, tx_ready = 1, busy = 0.
REQ-016 A handshake SHALL occur on any rising edge where tx_valid and tx_ready are both 1; the next state is START.
REQ-017 piso_load SHALL be 1 during the first cycle of START only.
REQ-018 Each of START, each DATA bit, PARITY and each STOP bit SHALL last exactly CLKS_PER_BIT cycles.
REQ-019 The bit period SHALL be timed by a baud counter that clears on entry to each bit and wraps at CLKS_PER_BIT-1.
REQ-020 The START -> DATA transition SHALL occur after one bit period; in START, select = 00.
REQ-021 In DATA, select SHALL be 01, and a bit counter SHALL count from 0 to DATA_BITS-1.
REQ-022 In DATA, piso_shift SHALL pulse in the last cycle of each data bit (DATA_BITS pulses per frame).
REQ-023 DATA SHALL exit after the last data bit: to PARITY if PARITY_EN = 1, otherwise to STOP.
REQ-024 In PARITY, select SHALL be 10 for one bit period; the next state is STOP.
REQ-025 In STOP, select SHALL be 11 for STOP_BITS bit periods, after which the FSM returns to IDLE.
REQ-026 tx_done SHALL pulse in the last cycle of the STOP state.
REQ-027 A new handshake SHALL NOT be accepted before the first cycle of IDLE.
REQ-028 busy SHALL equal NOT tx_ready in every cycle.
REQ-029 Frame length from the handshake edge back to IDLE SHALL be (1 + DATA_BITS + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles.
REQ-030 tx_valid SHALL be ignored whenever the FSM is not in IDLE.
REQ-031 The baud counter SHALL be wide enough for CLKS_PER_BIT-1 with no overflow; the bit counter SHALL be 3 bits wide.
REQ-032 piso_load and piso_shift SHALL never be 1 in the same cycle.
REQ-033 tx_done and piso_load SHALL never be 1 in the same cycle.

Reset
REQ-034 When rst = 1 at a clock edge, the FSM SHALL go to IDLE and the baud counter and bit counter SHALL clear to 0.
REQ-035 While in reset and on the cycle after: select = 11, tx_ready = 1, busy = 0, piso_load = 0, piso_shift = 0, tx_done = 0.
REQ-036 Reset in the middle of a frame SHALL abort that frame with no tx_done pulse.
REQ-037 rst SHALL take priority over a simultaneous handshake.

Structure
REQ-038 A shared package uart_pkg SHALL hold the FSM state enum and the select encodings SEL_START, SEL_DATA, SEL_PARITY and SEL_STOP.
REQ-039 The bit-period timer SHALL be one sub-module, baud_counter, with ports clk, rst, clear and tick.
REQ-040 All outputs SHALL be decoded from registered state and counters only, with no combinational path from tx_valid, except tx_ready.

Verification
REQ-041 Reset with CLKS_PER_BIT = 4: select = 11, tx_ready = 1, and all pulse outputs 0.
REQ-042 Defaults with CLKS_PER_BIT = 4 and one tx_valid pulse: the select sequence SHALL be 00 for 4 cycles, 01 for 32, 10 for 4, 11 for 4; tx_done SHALL pulse at cycle 44; the bench SHALL count 8 piso_shift pulses.
REQ-043 PARITY_EN = 0 and STOP_BITS = 2: no select = 10 cycle; frame length SHALL be 44 cycles.
REQ-044 tx_valid held high continuously: frames SHALL run back to back, with exactly one IDLE cycle and one piso_load per frame.
REQ-045 rst asserted during DATA bit 3: the next cycle SHALL show IDLE outputs and no tx_done; a following tx_valid SHALL start a clean frame.
REQ-046 tx_valid pulsed during STOP: the pulse SHALL be ignored, and no second frame SHALL start unless tx_valid is high while in IDLE.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit controller: FSM states and mux selects.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  localparam logic [1:0] SEL_START  = 2'b00;
  localparam logic [1:0] SEL_DATA   = 2'b01;
  localparam logic [1:0] SEL_PARITY = 2'b10;
  localparam logic [1:0] SEL_STOP   = 2'b11;

  localparam int unsigned BIT_CNT_W = 3;

endpackage

// File: rtl/baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module baud_counter #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Free-running wrap counter, held at zero while cleared so each frame starts aligned.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/tx_controller.sv
// UART transmit sequencer: steps start/data/parity/stop bits and drives the PISO and tx mux.
module tx_controller
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_EN    = 1,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       piso_load,
  output logic       piso_shift,
  output logic [1:0] select,
  output logic       busy,
  output logic       tx_done
);

  localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_STOP = BIT_CNT_W'(STOP_BITS - 1);

  tx_state_t            r_state;
  tx_state_t            w_state_nxt;
  logic [BIT_CNT_W-1:0] r_bit;
  logic [BIT_CNT_W-1:0] w_bit_nxt;
  logic                 r_load;
  logic                 w_load_nxt;
  logic                 w_tick;
  logic                 w_clear;

  // Baud timer is held cleared while idle so the start bit begins at count zero.
  assign w_clear = (r_state == ST_IDLE);

  baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(w_clear),
    .tick (w_tick)
  );

  // State, bit counter and the first-cycle-of-start flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_bit   <= '0;
      r_load  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_bit   <= w_bit_nxt;
      r_load  <= w_load_nxt;
    end
  end

  // Next-state logic; the bit counter is reused to count stop bits.
  always_comb begin
    w_state_nxt = r_state;
    w_bit_nxt   = r_bit;
    w_load_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (tx_valid) begin
          w_state_nxt = ST_START;
          w_bit_nxt   = '0;
          w_load_nxt  = 1'b1;
        end
      end
      ST_START: begin
        if (w_tick) begin
          w_state_nxt = ST_DATA;
          w_bit_nxt   = '0;
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          if (r_bit == LAST_DATA) begin
            w_state_nxt = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            w_bit_nxt   = '0;
          end else begin
            w_bit_nxt = r_bit + BIT_CNT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (w_tick) begin
          w_state_nxt = ST_STOP;
          w_bit_nxt   = '0;
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          if (r_bit == LAST_STOP) begin
            w_state_nxt = ST_IDLE;
            w_bit_nxt   = '0;
          end else begin
            w_bit_nxt = r_bit + BIT_CNT_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_bit_nxt   = '0;
      end
    endcase
  end

  // Output decode from registered state; reset forces the idle view immediately.
  always_comb begin
    select     = SEL_STOP;
    tx_ready   = 1'b1;
    piso_load  = 1'b0;
    piso_shift = 1'b0;
    tx_done    = 1'b0;
    if (!rst) begin
      case (r_state)
        ST_IDLE: begin
          tx_ready = 1'b1;
        end
        ST_START: begin
          select    = SEL_START;
          tx_ready  = 1'b0;
          piso_load = r_load;
        end
        ST_DATA: begin
          select     = SEL_DATA;
          tx_ready   = 1'b0;
          piso_shift = w_tick;
        end
        ST_PARITY: begin
          select   = SEL_PARITY;
          tx_ready = 1'b0;
        end
        ST_STOP: begin
          select   = SEL_STOP;
          tx_ready = 1'b0;
          tx_done  = w_tick && (r_bit == LAST_STOP);
        end
        default: begin
          tx_ready = 1'b1;
        end
      endcase
    end
  end

  assign busy = ~tx_ready;

endmodule
